// File: rtl/instr_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : instr_mem_loader
// Function : Byte-stream loader. It assembles bytes into little-endian 32-bit
//            words, writes them to the instruction memory and holds the CPU
//            while a load is in progress.
// Options  : LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
// Revision : 1.0
// ============================================================================
module instr_mem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 256,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    output logic             byte_ready,
    output logic             wr_en,
    output logic [31:0]      wr_addr,
    output logic [31:0]      wr_data,
    output logic             cpu_hold,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] word_count
);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_len_hi = 3'd1;
    localparam logic [2:0] c_st_len_lo = 3'd2;
    localparam logic [2:0] c_st_data   = 3'd3;
    localparam logic [2:0] c_st_write  = 3'd4;
    localparam logic [2:0] c_st_done   = 3'd5;
    localparam logic [2:0] c_st_csum   = 3'd6;

    localparam logic [CNT_W-1:0] c_max_words = CNT_W'(MAX_WORDS);

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [CNT_W-1:0] r_len;
    logic [1:0]       r_idx;
    logic [31:0]      r_word;
    logic [31:0]      r_wr_addr;
    logic [31:0]      r_wr_data;
    logic             r_err;
    logic [CNT_W-1:0] r_word_count;

    logic             w_accept;
    logic             w_start_ok;
    logic [CNT_W-1:0] w_len_new;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_last;

    assign w_accept   = byte_valid & byte_ready;
    assign w_start_ok = start & ((r_state == c_st_idle) | (r_state == c_st_done));
    assign w_len_new  = CNT_W'({r_len[15:8], byte_in});
    assign w_cnt_inc  = r_word_count + CNT_W'(1);
    assign w_last     = (w_cnt_inc == r_len);

    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign err        = r_err;
    assign word_count = r_word_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        byte_ready  = 1'b0;
        cpu_hold    = 1'b0;
        wr_en       = 1'b0;
        done        = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (start) w_state_nxt = c_st_len_hi;
            end
            c_st_len_hi: begin
                byte_ready = 1'b1;
                cpu_hold   = 1'b1;
                if (w_accept) w_state_nxt = c_st_len_lo;
            end
            c_st_len_lo: begin
                byte_ready = 1'b1;
                cpu_hold   = 1'b1;
                if (w_accept) begin
                    if ((w_len_new == '0) || (w_len_new > c_max_words)) w_state_nxt = c_st_done;
                    else                                                  w_state_nxt = c_st_data;
                end
            end
            c_st_data: begin
                byte_ready = 1'b1;
                cpu_hold   = 1'b1;
                if (w_accept && (r_idx == 2'd3)) w_state_nxt = c_st_write;
            end
            c_st_write: begin
                cpu_hold = 1'b1;
                wr_en    = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                w_state_nxt = w_last ? c_st_csum : c_st_data;
`else
                w_state_nxt = w_last ? c_st_done : c_st_data;
`endif
            end
`ifdef LOADER_CHECKSUM_EN
            c_st_csum: begin
                byte_ready = 1'b1;
                cpu_hold   = 1'b1;
                if (w_accept) w_state_nxt = c_st_done;
            end
`endif
            c_st_done: begin
                done = 1'b1;
                if (start) w_state_nxt = c_st_len_hi;
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] r_csum;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_len        <= '0;
            r_idx        <= '0;
            r_word       <= '0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_err        <= 1'b0;
            r_word_count <= '0;
`ifdef LOADER_CHECKSUM_EN
            r_csum       <= '0;
`endif
        end else begin
            if (w_start_ok) begin
                r_err        <= 1'b0;
                r_word_count <= '0;
                r_idx        <= '0;
`ifdef LOADER_CHECKSUM_EN
                r_csum       <= '0;
`endif
            end
            case (r_state)
                c_st_len_hi: if (w_accept) r_len <= CNT_W'({byte_in, 8'h00});
                c_st_len_lo: begin
                    if (w_accept) begin
                        r_len <= w_len_new;
                        if (w_len_new > c_max_words) r_err <= 1'b1;
                    end
                end
                c_st_data: begin
                    if (w_accept) begin
                        r_word[{r_idx, 3'b000} +: 8] <= byte_in;
                        r_idx <= r_idx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        r_csum <= r_csum ^ byte_in;
`endif
                        // Latch the write port one cycle early so it is stable throughout WRITE.
                        if (r_idx == 2'd3) begin
                            r_wr_data <= {byte_in, r_word[23:0]};
                            r_wr_addr <= BASE_ADDR + (32'(r_word_count) << 2);
                        end
                    end
                end
                c_st_write: r_word_count <= w_cnt_inc;
`ifdef LOADER_CHECKSUM_EN
                c_st_csum: if (w_accept && (byte_in != r_csum)) r_err <= 1'b1;
`endif
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
